// File: rtl/hw4_pkg.sv
// Shared types and constants for the serial feed stage.
package hw4_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } loader_state_t;

   localparam int unsigned LOADER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_loader.sv
// Parallel-to-serial feed stage for the downstream muxdff chain.
// Accepts a word on a valid/ready handshake and shifts it out MSB-first.
// Sel_out steers the downstream cell onto the serial bit only while a bit
// is actually being consumed; otherwise the cell recirculates its D0 path.
module serial_loader
   import hw4_pkg::*;
#(
   parameter int unsigned WIDTH = LOADER_WIDTH_DEFAULT
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Data,
   input  logic             Load_valid,
   output logic             Load_ready,
   input  logic             Hold,
   output logic             Bit_out,
   output logic             Sel_out,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned CW = $clog2(WIDTH);

   loader_state_t    state;
   loader_state_t    state_next;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    count;

   // State register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode; only Sel_out looks at an input (Hold).
   always_comb begin
      state_next = state;
      Load_ready = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      Sel_out    = 1'b0;
      Bit_out    = 1'b0;
      case (state)
         IDLE: begin
            Load_ready = 1'b1;
            if (Load_valid) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            Busy    = 1'b1;
            Bit_out = shreg[WIDTH-1];
            Sel_out = !Hold;
            if (!Hold && (count == '0)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            Busy       = 1'b1;
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shift register and bit counter; both freeze while Hold stalls a shift.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         shreg <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Load_valid) begin
                  shreg <= Data;
                  count <= CW'(WIDTH - 1);
               end
            end
            SHIFT: begin
               if (!Hold) begin
                  shreg <= {shreg[WIDTH-2:0], 1'b0};
                  if (count != '0) begin
                     count <= count - 1'b1;
                  end
               end
            end
            default: begin
               shreg <= shreg;
               count <= count;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader (WIDTH = 8).
module tb_serial_loader;

   localparam int unsigned W = 8;

   logic         Clock;
   logic         Reset_n;
   logic [W-1:0] Data;
   logic         Load_valid;
   logic         Load_ready;
   logic         Hold;
   logic         Bit_out;
   logic         Sel_out;
   logic         Busy;
   logic         Done;

   int unsigned checks;
   int unsigned failures;

   serial_loader #(.WIDTH(W)) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Data       (Data),
      .Load_valid (Load_valid),
      .Load_ready (Load_ready),
      .Hold       (Hold),
      .Bit_out    (Bit_out),
      .Sel_out    (Sel_out),
      .Busy       (Busy),
      .Done       (Done)
   );

   // 50 MHz clock.
   initial Clock = 1'b0;
   always #10 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Runs one word from an idle DUT. Called 1 time unit after a rising edge.
   // hmask/lvmask bit c gives Hold / Load_valid during cycle c after acceptance.
   // The model counts consumed bits: a cycle consumes a bit when fewer than W
   // bits are consumed and Hold is low; once all W are consumed the next cycle
   // is the Done cycle, and the one after that is idle.
   task automatic run_word(input logic [W-1:0] data, input logic [31:0] hmask,
                           input logic [31:0] lvmask, output logic [W-1:0] got,
                           output int unsigned done_at);
      int unsigned consumed;
      int unsigned npulse;
      logic        h;
      logic        active;
      logic        finished;
      Data       = data;
      Load_valid = 1'b1;
      Hold       = 1'b0;
      @(posedge Clock); #1;
      Load_valid = 1'b0;
      Data       = ~data;
      consumed   = 0;
      npulse     = 0;
      done_at    = 0;
      got        = '0;
      finished   = 1'b0;
      for (int c = 1; c < 40 && !finished; c++) begin
         h          = (c < 32) ? hmask[c] : 1'b0;
         active     = (consumed < W) || (done_at == 0);
         Hold       = h;
         Load_valid = (active && c < 32) ? lvmask[c] : 1'b0;
         Data       = Load_valid ? '0 : ~data;
         @(negedge Clock);
         if (consumed < W) begin
            check("shift_bit",   Bit_out, data[W-1-consumed]);
            check("shift_sel",   Sel_out, !h);
            check("shift_busy",  Busy, 1);
            check("shift_done",  Done, 0);
            check("shift_ready", Load_ready, 0);
            if (Sel_out) got = {got[W-2:0], Bit_out};
            if (!h) consumed++;
         end else if (done_at == 0) begin
            check("done_flag",  Done, 1);
            check("done_busy",  Busy, 1);
            check("done_sel",   Sel_out, 0);
            check("done_bit",   Bit_out, 0);
            check("done_ready", Load_ready, 0);
            done_at = c;
         end else begin
            check("idle_ready", Load_ready, 1);
            check("idle_busy",  Busy, 0);
            check("idle_done",  Done, 0);
            check("idle_sel",   Sel_out, 0);
            finished = 1'b1;
         end
         if (Done) npulse++;
         @(posedge Clock); #1;
      end
      Load_valid = 1'b0;
      Hold       = 1'b0;
      check("word_finished", finished, 1);
      check("done_pulses", npulse, 1);
   endtask

   typedef struct {
      logic [W-1:0] data;
      logic [31:0]  hold_mask;
      logic [31:0]  lv_mask;
      logic [W-1:0] exp_stream;
      int unsigned  exp_done;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [W-1:0]  got;
      int unsigned   done_at;
      int unsigned   ndone;
      int unsigned   first_ready;
      logic [15:0]   stream;

      checks     = 0;
      failures   = 0;
      Reset_n    = 1'b1;
      Data       = 8'hA5;
      Load_valid = 1'b1;
      Hold       = 1'b0;

      vecs[0] = '{data: 8'hA5, hold_mask: 32'h0,   lv_mask: 32'h0,  exp_stream: 8'b1010_0101, exp_done: 9};
      vecs[1] = '{data: 8'hF0, hold_mask: 32'h38,  lv_mask: 32'h0,  exp_stream: 8'b1111_0000, exp_done: 12};
      vecs[2] = '{data: 8'hFF, hold_mask: 32'h0,   lv_mask: 32'h54, exp_stream: 8'b1111_1111, exp_done: 9};
      vecs[3] = '{data: 8'hC3, hold_mask: 32'h300, lv_mask: 32'h0,  exp_stream: 8'b1100_0011, exp_done: 11};

      // Reset with Load_valid held high.
      #2 Reset_n = 1'b0;
      #1;
      check("rst_ready", Load_ready, 1);
      check("rst_busy",  Busy, 0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_hold_ready", Load_ready, 1);
      check("rst_hold_bit",   Bit_out, 0);
      check("rst_hold_sel",   Sel_out, 0);
      check("rst_hold_busy",  Busy, 0);
      check("rst_hold_done",  Done, 0);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      @(posedge Clock); #1;
      Load_valid = 1'b0;
      Data       = '0;
      @(negedge Clock);
      check("first_edge_busy",  Busy, 1);
      check("first_edge_bit",   Bit_out, 1);
      check("first_edge_sel",   Sel_out, 1);
      check("first_edge_ready", Load_ready, 0);
      repeat (10) @(posedge Clock);
      #1;
      check("first_word_idle", Load_ready, 1);

      // Table-driven words.
      for (int unsigned i = 0; i < 4; i++) begin
         run_word(vecs[i].data, vecs[i].hold_mask, vecs[i].lv_mask, got, done_at);
         check($sformatf("vec%0d_stream", i), got, vecs[i].exp_stream);
         check($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].exp_done);
      end

      // Reset in the middle of 8'h3C after four bits.
      Data       = 8'h3C;
      Load_valid = 1'b1;
      @(posedge Clock); #1;
      Load_valid = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      check("abort_busy_before", Busy, 1);
      Reset_n = 1'b0;
      #1;
      check("abort_ready", Load_ready, 1);
      check("abort_busy",  Busy, 0);
      check("abort_done",  Done, 0);
      check("abort_sel",   Sel_out, 0);
      check("abort_bit",   Bit_out, 0);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge Clock);
         if (Done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_idle_ready", Load_ready, 1);
      @(posedge Clock); #1;

      // Back-to-back words with Load_valid held high.
      Data       = 8'h81;
      Load_valid = 1'b1;
      @(posedge Clock); #1;
      Data        = 8'h7E;
      stream      = '0;
      ndone       = 0;
      first_ready = 0;
      for (int c = 1; c <= 22; c++) begin
         if (c == 11) begin
            Load_valid = 1'b0;
            Data       = '0;
         end
         @(negedge Clock);
         if (Sel_out) stream = {stream[14:0], Bit_out};
         if (Load_ready && first_ready == 0) first_ready = c;
         if (Done) ndone++;
         @(posedge Clock); #1;
      end
      check("b2b_accept_gap", first_ready, W + 2);
      check("b2b_stream", stream, 16'h817E);
      check("b2b_done_count", ndone, 2);

      // Randomized words, holds and ignored Load_valid pulses.
      for (int unsigned i = 0; i < 20; i++) begin
         logic [W-1:0] rd;
         logic [31:0]  hm;
         logic [31:0]  lm;
         int unsigned  nh;
         rd = W'($urandom);
         hm = $urandom & $urandom & 32'h001F_FFFE;
         lm = $urandom;
         run_word(rd, hm, lm, got, done_at);
         check("rand_stream", got, rd);
         // Holds only delay the word while bits remain; count those.
         nh = 0;
         for (int c = 1, k = 0; k < W; c++) begin
            if (hm[c]) nh++; else k++;
         end
         check("rand_done_cycle", done_at, W + 1 + nh);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
